lif_layer_q14: RTL

Q1.14 leaky integrate-and-fire layer that turns one timestep's pre-synaptic spike vector into the post-synaptic spike vector consumed by the STDP stage. Membranes are updated sequentially: leak all N neurons, then accumulate weights over the F inputs, skipping silent inputs. Weights are read from the same F*N weight memory the STDP stage writes, at address f*N+n. Processing ends with a threshold/fire/refractory pass.

---
 rtl/snn_q14_pkg.sv | 40 ++++
 rtl/lif_layer_q14_if.sv | 20 ++
 rtl/q14_mul_round.sv | 30 +++
 rtl/lif_layer_q14.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/snn_q14_pkg.sv
// -----------------------------------------------------------------------------
// snn_q14_pkg
// Shared Q1.14 definitions for the spiking layers:
//   Q / ROUND_BIAS  fixed-point fraction width and half-LSB rounding bias
//   lif_state_e     sequencer states of the LIF layer
//   fn_addr()       row-major weight address f*n_count+n
//   sat32()         clamp a 48-bit signed value to the 32-bit signed range
// -----------------------------------------------------------------------------
package snn_q14_pkg;

  localparam int Q = 14;
  localparam logic signed [47:0] ROUND_BIAS = 48'sd1 <<< (Q - 1);

  localparam logic signed [47:0] SAT_HI = 48'sd2147483647;
  localparam logic signed [47:0] SAT_LO = -48'sd2147483648;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAK,
    S_ACCUM,
    S_DRAIN,
    S_FIRE,
    S_DONE
  } lif_state_e;

  // Row-major weight layout shared with the STDP writer. The caller narrows the
  // result to its own address width.
  function automatic int unsigned fn_addr(input int unsigned f,
                                          input int unsigned n,
                                          input int unsigned n_count);
    return f * n_count + n;
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [47:0] x);
    if (x > SAT_HI) return 32'sh7FFF_FFFF;
    if (x < SAT_LO) return 32'sh8000_0000;
    return x[31:0];
  endfunction

endpackage

// File: rtl/lif_layer_q14_if.sv
// -----------------------------------------------------------------------------
// lif_layer_q14_if
// Read port of the shared F*N weight memory.
//   w_re     read strobe (layer -> memory)
//   w_addr   weight address f*N+n (layer -> memory)
//   w_rdata  signed Q1.14 weight, valid one clock after w_re (memory -> layer)
// master = the layer, slave = the weight memory.
// -----------------------------------------------------------------------------
interface lif_layer_q14_if #(
  parameter int AW = 13
) ();

  logic                w_re;
  logic [AW-1:0]       w_addr;
  logic signed [15:0]  w_rdata;

  modport master (output w_re, output w_addr, input  w_rdata);
  modport slave  (input  w_re, input  w_addr, output w_rdata);

endinterface

// File: rtl/q14_mul_round.sv
// -----------------------------------------------------------------------------
// q14_mul_round
// Combinational Q1.14 scale: o_y = sat32(round(i_a * i_v / 2^Q)).
//   i_a  signed 16-bit Q1.14 factor
//   i_v  signed 32-bit Q1.14 value
//   o_y  signed 32-bit result, rounded half away from zero, saturated
// Rounding works on the magnitude so that negative results are the mirror of
// positive ones (-1.5 -> -2, -0.25 -> 0).
// -----------------------------------------------------------------------------
module q14_mul_round
  import snn_q14_pkg::*;
(
  input  logic signed [15:0] i_a,
  input  logic signed [31:0] i_v,
  output logic signed [31:0] o_y
);

  logic signed [47:0] w_prod;
  logic signed [47:0] w_mag;
  logic signed [47:0] w_rnd;
  logic               w_neg;

  // |product| <= 2^46, so the magnitude and the biased sum fit in 48 bits.
  assign w_prod = 48'(i_a) * 48'(i_v);
  assign w_neg  = w_prod[47];
  assign w_mag  = w_neg ? -w_prod : w_prod;
  assign w_rnd  = (w_mag + ROUND_BIAS) >>> Q;
  assign o_y    = sat32(w_neg ? -w_rnd : w_rnd);

endmodule

// File: rtl/lif_layer_q14.sv
// -----------------------------------------------------------------------------
// lif_layer_q14
// One timestep of a leaky integrate-and-fire layer in Q1.14.
// Sequence: LEAK (N cycles) -> ACCUM (N cycles per active input, 1 per silent
// input) -> DRAIN (1) -> FIRE (N) -> DONE (1).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a timestep (accepted only when idle)
//   pre_bits[F]     pre-synaptic spikes, latched on start
//   alpha           Q1.14 leak factor, latched on start
//   v_th, v_reset   firing threshold / post-spike membrane value, latched
//   refrac_cycles   refractory timesteps after a spike, latched
//   wbus            weight memory read port (master)
//   busy            timestep in progress
//   done            one-cycle pulse, post_bits valid in the same cycle
//   post_bits[N]    spikes of the last completed timestep
// -----------------------------------------------------------------------------
module lif_layer_q14
  import snn_q14_pkg::*;
#(
  parameter  int F  = 48,
  parameter  int N  = 96,
  parameter  int RW = 8,
  localparam int AW = $clog2(F * N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [F-1:0]          pre_bits,
  input  logic signed [15:0]    alpha,
  input  logic signed [31:0]    v_th,
  input  logic signed [31:0]    v_reset,
  input  logic [RW-1:0]         refrac_cycles,
  lif_layer_q14_if.master       wbus,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          post_bits
);

  localparam int FW = (F > 1) ? $clog2(F) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  lif_state_e          r_state;
  lif_state_e          w_next_state;

  logic [NW-1:0]       r_n;
  logic [NW-1:0]       r_n_d;
  logic [FW-1:0]       r_f;
  logic                r_add_pend;
  logic [AW-1:0]       r_w_addr;

  logic [F-1:0]        r_pre;
  logic signed [15:0]  r_alpha;
  logic signed [31:0]  r_v_th;
  logic signed [31:0]  r_v_reset;
  logic [RW-1:0]       r_refrac_cycles;

  logic signed [31:0]  r_v      [N];
  logic [RW-1:0]       r_refrac [N];
  logic [N-1:0]        r_shadow;
  logic [N-1:0]        r_post;

  logic                w_last_n;
  logic                w_last_f;
  logic                w_rd;
  logic [AW-1:0]       w_rd_addr;
  logic signed [31:0]  w_leak_v;
  logic signed [31:0]  w_acc_v;
  logic                w_spike;
  logic [N-1:0]        w_shadow_nxt;

  assign w_last_n  = (r_n == NW'(N - 1));
  assign w_last_f  = (r_f == FW'(F - 1));
  assign w_rd      = (r_state == S_ACCUM) && r_pre[r_f];
  assign w_rd_addr = AW'(fn_addr(32'(r_f), 32'(r_n), N));

  q14_mul_round u_leak (
    .i_a (r_alpha),
    .i_v (r_v[r_n]),
    .o_y (w_leak_v)
  );

  // The weight read in the previous cycle lands on the neuron index captured
  // with it (r_n_d), not on the one currently being addressed.
  assign w_acc_v = sat32(48'(r_v[r_n_d]) + 48'(wbus.w_rdata));

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_spike           = (r_refrac[r_n] == '0) && (r_v[r_n] >= r_v_th);
    w_shadow_nxt      = r_shadow;
    w_shadow_nxt[r_n] = w_spike;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start)    w_next_state = S_LEAK;
      S_LEAK:  if (w_last_n) w_next_state = S_ACCUM;
      S_ACCUM: if (w_last_f && (!w_rd || w_last_n)) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_FIRE;
      S_FIRE:  if (w_last_n) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n             <= '0;
      r_n_d           <= '0;
      r_f             <= '0;
      r_add_pend      <= 1'b0;
      r_w_addr        <= '0;
      r_pre           <= '0;
      r_alpha         <= '0;
      r_v_th          <= '0;
      r_v_reset       <= '0;
      r_refrac_cycles <= '0;
      r_shadow        <= '0;
      r_post          <= '0;
      // NOTE: the membrane and refractory arrays are flops, not RAM, and are
      // cleared here so a reset mid-timestep restarts every neuron from v=0.
      for (int i = 0; i < N; i++) begin
        r_v[i]      <= '0;
        r_refrac[i] <= '0;
      end
    end else begin
      r_add_pend <= w_rd;
      r_n_d      <= r_n;

      // Pending accumulate; it never coincides with a LEAK or FIRE write.
      if (r_add_pend && (r_refrac[r_n_d] == '0)) r_v[r_n_d] <= w_acc_v;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pre           <= pre_bits;
            r_alpha         <= alpha;
            r_v_th          <= v_th;
            r_v_reset       <= v_reset;
            r_refrac_cycles <= refrac_cycles;
            r_n             <= '0;
            r_f             <= '0;
            r_shadow        <= '0;
          end
        end
        S_LEAK: begin
          r_v[r_n] <= (r_refrac[r_n] != '0) ? r_v_reset : w_leak_v;
          r_n      <= w_last_n ? '0 : r_n + 1'b1;
        end
        S_ACCUM: begin
          if (w_rd) begin
            r_w_addr <= w_rd_addr;
            if (w_last_n) begin
              r_n <= '0;
              r_f <= r_f + 1'b1;
            end else begin
              r_n <= r_n + 1'b1;
            end
          end else begin
            r_f <= r_f + 1'b1;
          end
        end
        S_FIRE: begin
          r_shadow <= w_shadow_nxt;
          if (w_spike) begin
            r_v[r_n]      <= r_v_reset;
            r_refrac[r_n] <= r_refrac_cycles;
          end else if (r_refrac[r_n] != '0) begin
            r_refrac[r_n] <= r_refrac[r_n] - 1'b1;
          end
          if (w_last_n) begin
            r_post <= w_shadow_nxt;
            r_n    <= '0;
          end else begin
            r_n <= r_n + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign post_bits   = r_post;
  assign wbus.w_re   = w_rd;
  assign wbus.w_addr = w_rd ? w_rd_addr : r_w_addr;

endmodule
